// File: rtl/counter_sequencer_if.sv
// Command and status bundle of counter_sequencer. The master drives the commands
// (start/stop/pause, plus dir/mode/limit sampled on start) and the slave returns q, busy, done and state.
interface counter_sequencer_if #(
    parameter int WIDTH = 7
);
    // There is no valid/ready pair. Each command is a plain level that is sampled on
    // every rising clk edge. Within a cycle stop beats start, and start beats pause.
    logic             start;
    logic             stop;
    logic             pause;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, stop, pause, dir, mode, limit,
        input  q, busy, done, state
    );

    modport slave (
        input  start, stop, pause, dir, mode, limit,
        output q, busy, done, state
    );
endinterface

// File: rtl/counter_sequencer.sv
// Sequencer for an up/down WIDTH-bit counter. It has one-shot and auto-reload modes, pause and stop.
// Defining CTRL_PRESCALE_EN adds a prescaler, so the count steps once every PRESCALE clocks.
module counter_sequencer #(
    parameter int WIDTH    = 7,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                reset,
    counter_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] lim_q;
    logic             dir_q;
    logic             mode_q;
    logic             done_q;
    logic             busy_q;

    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] init;
    logic             tick;
    logic             hit;

    assign term = dir_q ? '0 : lim_q;
    assign init = dir_q ? lim_q : '0;
    assign hit  = tick && (q_q == term);

`ifdef CTRL_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);
    logic [PW-1:0] ps_q;

    assign tick = (ps_q == PW'(PRESCALE - 1));

    // The prescaler advances only on RUN edges that are not a pause. It wraps on tick,
    // and that includes the terminal edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q <= '0;
        end else if (bus.stop || (state_q == IDLE && bus.start)) begin
            ps_q <= '0;
        end else if (state_q == RUN && (hit || !bus.pause)) begin
            ps_q <= tick ? '0 : ps_q + 1'b1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            lim_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                q_q     <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            lim_q   <= bus.limit;
                            dir_q   <= bus.dir;
                            mode_q  <= bus.mode;
                            q_q     <= bus.dir ? bus.limit : '0;
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                    RUN: begin
                        // A terminal edge takes priority over a pause raised on the same edge.
                        if (hit) begin
                            done_q <= 1'b1;
                            if (mode_q) begin
                                q_q <= init;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else if (bus.pause) begin
                            state_q <= PAUSED;
                        end else if (tick) begin
                            q_q <= dir_q ? q_q - 1'b1 : q_q + 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (!bus.pause) begin
                            state_q <= RUN;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.q     = q_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;

endmodule
